mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between three requesters:
  - instruction-cache line fill (read)
  - data-cache line fill (read)
  - store-buffer drain (word write)
- Sits between the caches/store buffer and main memory.
- Sequences one transaction at a time with a grant / hold / acknowledge FSM.
- Fixed priority, with an optional anti-starvation promotion for store-buffer drains.

Parameters:
- ADDRESS_BITS, 32, address width of all ports.
- DATA_BITS, 32, store write-data width.
- LINE_BITS, 128, fill data width returned by memory.
- STARVE_LIMIT, 8, cycles a pending store waits before promotion (used only with the optional feature).
- STARVE_BITS, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iReq  in  1  icache fill request, held until iAck
- iAddr  in  ADDRESS_BITS  icache fill address
- iAck  out  1  one-cycle pulse; iData valid this cycle
- iData  out  LINE_BITS  fill line for icache
- dReq  in  1  dcache fill request, held until dAck
- dAddr  in  ADDRESS_BITS  dcache fill address
- dAck  out  1  one-cycle pulse; dData valid this cycle
- dData  out  LINE_BITS  fill line for dcache
- sReq  in  1  store-buffer drain request (head valid)
- sAddr  in  ADDRESS_BITS  store address
- sData  in  DATA_BITS  store data
- sAck  out  1  one-cycle pulse; store buffer retires head
- memReq  out  1  memory transaction request
- memWe  out  1  1 = write, 0 = read
- memAddr  out  ADDRESS_BITS  memory address
- memWData  out  DATA_BITS  write data
- memAck  in  1  memory completion, one cycle
- memRData  in  LINE_BITS  read data, valid with memAck

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset:
  - state IDLE; grant register NONE; starvation counter 0.
  - memReq, memWe, iAck, dAck, sAck all 0; memAddr, memWData, iData, dData all 0.
- IDLE, when any request is high:
  - Select the winner: dReq > iReq > sReq.
  - Latch winner id, address, write data and we (1 only for store) into registers.
  - Next state BUSY.
- IDLE, no request: stay IDLE.
- BUSY:
  - memReq = 1; memWe/memAddr/memWData driven from latched registers, stable the whole state.
  - Requester inputs changing during BUSY are ignored.
  - On memAck: latch memRData into the return register; next state DONE.
  - Without memAck: stay BUSY indefinitely; no timeout.
- DONE:
  - memReq = 0.
  - Exactly one of iAck/dAck/sAck = 1, matching the latched winner.
  - iData/dData present the latched line; they hold their value until the next fill completes.
  - Next state IDLE.
- Requesters see their ack at the end of DONE. Arbitration in the following IDLE cycle uses the updated request lines, so a back-to-back store-buffer drain is granted afresh and never double-acked.
- Minimum transaction: 3 cycles (IDLE → BUSY → DONE) plus memory latency; peak throughput 1 transaction per (memory latency + 2) cycles.
- memAck arriving in IDLE or DONE is ignored.
- Simultaneous requests: only the winner is latched; losers remain pending and compete again in the next IDLE.
- Reset mid-transaction: the FSM returns to IDLE immediately, with no ack pulsed and memReq dropped the following cycle. A late memAck is then ignored.
- The store data path is DATA_BITS wide. The arbiter performs no byte masking or sub-word merging.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro:
  - The counter increments (saturating at STARVE_LIMIT) each IDLE cycle in which sReq = 1 and another requester wins.
  - The counter resets to 0 when the store is granted, or when sReq = 0.
  - When the counter == STARVE_LIMIT, the store beats both fills in IDLE.
- Without the macro: no counter logic is present; pure fixed priority dReq > iReq > sReq.

Test Plan:
- Single icache fill: iReq=1, iAddr=0x100; memory acks 2 cycles after memReq with memRData=0xA5A5... → memWe=0, memAddr=0x100; exactly one iAck pulse with iData=0xA5A5...; total 5 cycles.
- Simultaneous dReq/iReq/sReq all 1 → grant order dcache, then icache, then store. The store write shows memWe=1, memAddr=sAddr, memWData=sData, followed by a single sAck.
- Store-buffer drain of 4 entries, sReq held high with address changing after each sAck → 4 memory writes, 4 sAck pulses, no duplicate write of any address.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=8: dReq kept continuously asserted, sReq=1 → store granted within 8 arbitration wins by dcache; counter cleared after the grant. Without the macro, the store is never granted while dReq stays high.
- rst asserted while in BUSY, memAck arriving 1 cycle later → no ack pulse on any port; memReq=0; FSM in IDLE; next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned LINE_BITS    = 128
);
    logic                    iReq;
    logic [ADDRESS_BITS-1:0] iAddr;
    logic                    iAck;
    logic [LINE_BITS-1:0]    iData;

    logic                    dReq;
    logic [ADDRESS_BITS-1:0] dAddr;
    logic                    dAck;
    logic [LINE_BITS-1:0]    dData;

    logic                    sReq;
    logic [ADDRESS_BITS-1:0] sAddr;
    logic [DATA_BITS-1:0]    sData;
    logic                    sAck;

    logic                    memReq;
    logic                    memWe;
    logic [ADDRESS_BITS-1:0] memAddr;
    logic [DATA_BITS-1:0]    memWData;
    logic                    memAck;
    logic [LINE_BITS-1:0]    memRData;

    modport slave (
        input  iReq, iAddr, dReq, dAddr, sReq, sAddr, sData, memAck, memRData,
        output iAck, iData, dAck, dData, sAck, memReq, memWe, memAddr, memWData
    );

    modport master (
        output iReq, iAddr, dReq, dAddr, sReq, sAddr, sData, memAck, memRData,
        input  iAck, iData, dAck, dData, sAck, memReq, memWe, memAddr, memWData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache fill, dcache fill and store drain (IDLE/BUSY/DONE).
// Define MEM_ARB_STARVE_GUARD_EN to promote a long-waiting store drain over both fills.
module mem_port_arbiter #(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned LINE_BITS    = 128,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned STARVE_BITS  = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;
    typedef enum logic [1:0] {GrantNone, GrantI, GrantD, GrantS} grantT;

    stateT                   stateQ;
    grantT                   grantQ;
    logic [ADDRESS_BITS-1:0] addrQ;
    logic [DATA_BITS-1:0]    wDataQ;
    logic                    weQ;
    logic                    memReqQ;
    logic                    iAckQ;
    logic                    dAckQ;
    logic                    sAckQ;
    logic [LINE_BITS-1:0]    iDataQ;
    logic [LINE_BITS-1:0]    dDataQ;

    grantT                   winner;
    logic [ADDRESS_BITS-1:0] winAddr;
    logic                    sPromote;

    // A promoted store overrides the fixed dcache > icache > store order.
    always_comb begin
        winner = GrantNone;
        if (bus.sReq && sPromote) begin
            winner = GrantS;
        end else if (bus.dReq) begin
            winner = GrantD;
        end else if (bus.iReq) begin
            winner = GrantI;
        end else if (bus.sReq) begin
            winner = GrantS;
        end
    end

    always_comb begin
        winAddr = bus.sAddr;
        case (winner)
            GrantI:  winAddr = bus.iAddr;
            GrantD:  winAddr = bus.dAddr;
            default: winAddr = bus.sAddr;
        endcase
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STARVE_BITS-1:0] starveCnt;

    assign sPromote = (starveCnt == STARVE_BITS'(STARVE_LIMIT));

    // Counts arbitration losses of a pending store; any IDLE with sReq high has a winner.
    always_ff @(posedge clk) begin
        if (rst || !bus.sReq) begin
            starveCnt <= '0;
        end else if (stateQ == StIdle) begin
            if (winner == GrantS) begin
                starveCnt <= '0;
            end else if (!sPromote) begin
                starveCnt <= starveCnt + STARVE_BITS'(1);
            end
        end
    end
`else
    assign sPromote = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            grantQ  <= GrantNone;
            addrQ   <= '0;
            wDataQ  <= '0;
            weQ     <= 1'b0;
            memReqQ <= 1'b0;
            iAckQ   <= 1'b0;
            dAckQ   <= 1'b0;
            sAckQ   <= 1'b0;
            iDataQ  <= '0;
            dDataQ  <= '0;
        end else begin
            iAckQ <= 1'b0;
            dAckQ <= 1'b0;
            sAckQ <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (winner != GrantNone) begin
                        grantQ  <= winner;
                        addrQ   <= winAddr;
                        wDataQ  <= bus.sData;
                        weQ     <= (winner == GrantS);
                        memReqQ <= 1'b1;
                        stateQ  <= StBusy;
                    end
                end
                StBusy: begin
                    if (bus.memAck) begin
                        memReqQ <= 1'b0;
                        iAckQ   <= (grantQ == GrantI);
                        dAckQ   <= (grantQ == GrantD);
                        sAckQ   <= (grantQ == GrantS);
                        if (grantQ == GrantI) begin
                            iDataQ <= bus.memRData;
                        end
                        if (grantQ == GrantD) begin
                            dDataQ <= bus.memRData;
                        end
                        stateQ <= StDone;
                    end
                end
                StDone: begin
                    grantQ <= GrantNone;
                    stateQ <= StIdle;
                end
                default: begin
                    memReqQ <= 1'b0;
                    grantQ  <= GrantNone;
                    stateQ  <= StIdle;
                end
            endcase
        end
    end

    // The starvation counter must be able to reach its limit.
    starveCfg: assert property (@(posedge clk) STARVE_LIMIT < 2 ** STARVE_BITS);

    assign bus.memReq   = memReqQ;
    assign bus.memWe    = weQ;
    assign bus.memAddr  = addrQ;
    assign bus.memWData = wDataQ;
    assign bus.iAck     = iAckQ;
    assign bus.dAck     = dAckQ;
    assign bus.sAck     = sAckQ;
    assign bus.iData    = iDataQ;
    assign bus.dData    = dDataQ;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a latency-2 memory model,
// and a monitor that checks each memory transaction and each ack against expectations.
module tb_mem_port_arbiter;
    localparam logic [1:0] KindI = 2'd0;
    localparam logic [1:0] KindD = 2'd1;
    localparam logic [1:0] KindS = 2'd2;

    typedef struct packed {
        logic [1:0]   kind;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] line;
    } txnT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRESS_BITS(32), .DATA_BITS(32), .LINE_BITS(128)) bus ();

    mem_port_arbiter #(
        .ADDRESS_BITS(32),
        .DATA_BITS(32),
        .LINE_BITS(128),
        .STARVE_LIMIT(8),
        .STARVE_BITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    txnT         memQ[$];
    txnT         ackQ[$];
    logic [31:0] iQ[$];
    logic [31:0] dQ[$];
    logic [31:0] sAddrQ[$];
    logic [31:0] sDataQ[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   riseCyc = 0;
    logic memAuto = 1'b1;
    logic manualAck = 1'b0;
    int   latCnt = 0;
    logic prevReq = 1'b0;
    txnT  cur;
    txnT  e;
    logic [1:0] ackKind;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expectTxn(input logic [1:0] kind, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [127:0] line);
        txnT t;
        t = '{kind: kind, addr: addr, wdata: wdata, line: line};
        memQ.push_back(t);
        ackQ.push_back(t);
    endtask

    function automatic logic [127:0] memLine(input logic [31:0] addr);
        return {4{addr ^ 32'hA5A5A5A5}};
    endfunction

    task automatic drain(input int maxCyc);
        int n;
        n = 0;
        while ((memQ.size() + ackQ.size() + iQ.size() + dQ.size() + sAddrQ.size()) != 0
               && n < maxCyc) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= maxCyc) begin
            fails++;
            $display("FAIL drain: %0d mem / %0d ack still pending after %0d cycles",
                     memQ.size(), ackQ.size(), n);
        end
        repeat (6) @(posedge clk);
        #2;
    endtask

    // Requesters: each holds its request until acked, then presents the next queued entry.
    initial begin
        bus.iReq = 1'b0;
        bus.iAddr = '0;
        forever begin
            @(negedge clk);
            if (bus.iAck && iQ.size() > 0) void'(iQ.pop_front());
            bus.iReq = (iQ.size() > 0);
            bus.iAddr = (iQ.size() > 0) ? iQ[0] : 32'h0;
        end
    end

    initial begin
        bus.dReq = 1'b0;
        bus.dAddr = '0;
        forever begin
            @(negedge clk);
            if (bus.dAck && dQ.size() > 0) void'(dQ.pop_front());
            bus.dReq = (dQ.size() > 0);
            bus.dAddr = (dQ.size() > 0) ? dQ[0] : 32'h0;
        end
    end

    initial begin
        bus.sReq = 1'b0;
        bus.sAddr = '0;
        bus.sData = '0;
        forever begin
            @(negedge clk);
            if (bus.sAck && sAddrQ.size() > 0) begin
                void'(sAddrQ.pop_front());
                void'(sDataQ.pop_front());
            end
            bus.sReq = (sAddrQ.size() > 0);
            bus.sAddr = (sAddrQ.size() > 0) ? sAddrQ[0] : 32'h0;
            bus.sData = (sDataQ.size() > 0) ? sDataQ[0] : 32'h0;
        end
    end

    // Memory: acks two cycles after first seeing memReq, or once on demand.
    initial begin
        bus.memAck = 1'b0;
        bus.memRData = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.memAck = 1'b0;
            if (manualAck) begin
                bus.memAck = 1'b1;
                bus.memRData = {4{32'hFFFF0000}};
                manualAck = 1'b0;
            end else if (memAuto && bus.memReq) begin
                if (latCnt == 2) begin
                    bus.memAck = 1'b1;
                    bus.memRData = memLine(bus.memAddr);
                    latCnt = 0;
                end else begin
                    latCnt++;
                end
            end else begin
                latCnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prevReq = 1'b0;
            end else begin
                if (bus.memReq && !prevReq) begin
                    cur = '{kind: KindI, addr: bus.memAddr, wdata: bus.memWData, line: '0};
                    cur.kind = bus.memWe ? KindS : KindI;
                    riseCyc = cyc;
                    if (memQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected mem txn: addr %0h we %0b", bus.memAddr,
                                 bus.memWe);
                    end else begin
                        e = memQ.pop_front();
                        chk("memWe", 128'(bus.memWe), 128'(e.kind == KindS));
                        chk("memAddr", 128'(bus.memAddr), 128'(e.addr));
                        if (e.kind == KindS) chk("memWData", 128'(bus.memWData), 128'(e.wdata));
                    end
                end else if (bus.memReq) begin
                    chk("memAddr stable", 128'(bus.memAddr), 128'(cur.addr));
                    chk("memWData stable", 128'(bus.memWData), 128'(cur.wdata));
                end
                if (bus.iAck || bus.dAck || bus.sAck) begin
                    chk("ack onehot", 128'({1'b0, bus.iAck} + {1'b0, bus.dAck} + {1'b0, bus.sAck}),
                        128'd1);
                    chk("memReq low in DONE", 128'(bus.memReq), 128'd0);
                    chk("ack latency", 128'(cyc - riseCyc), 128'd3);
                    ackKind = bus.dAck ? KindD : (bus.iAck ? KindI : KindS);
                    if (ackQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected ack: i %0b d %0b s %0b", bus.iAck, bus.dAck,
                                 bus.sAck);
                    end else begin
                        e = ackQ.pop_front();
                        chk("ack port", 128'(ackKind), 128'(e.kind));
                        if (ackKind == KindI) chk("iData", bus.iData, e.line);
                        if (ackKind == KindD) chk("dData", bus.dData, e.line);
                    end
                end
                prevReq = bus.memReq;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst memReq", 128'(bus.memReq), 128'd0);
        chk("rst memWe", 128'(bus.memWe), 128'd0);
        chk("rst memAddr", 128'(bus.memAddr), 128'd0);
        chk("rst memWData", 128'(bus.memWData), 128'd0);
        chk("rst acks", 128'({bus.iAck, bus.dAck, bus.sAck}), 128'd0);
        chk("rst iData", bus.iData, 128'd0);
        chk("rst dData", bus.dData, 128'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Single icache fill
        iQ.push_back(32'h100);
        expectTxn(KindI, 32'h100, 32'h0, 128'hA5A5A4A5_A5A5A4A5_A5A5A4A5_A5A5A4A5);
        drain(60);

        // All three at once: dcache, icache, then store
        dQ.push_back(32'h200);
        iQ.push_back(32'h300);
        sAddrQ.push_back(32'h400);
        sDataQ.push_back(32'hDEADBEEF);
        expectTxn(KindD, 32'h200, 32'h0, 128'hA5A5A7A5_A5A5A7A5_A5A5A7A5_A5A5A7A5);
        expectTxn(KindI, 32'h300, 32'h0, 128'hA5A5A6A5_A5A5A6A5_A5A5A6A5_A5A5A6A5);
        expectTxn(KindS, 32'h400, 32'hDEADBEEF, 128'h0);
        drain(80);
        chk("iData held", bus.iData, 128'hA5A5A6A5_A5A5A6A5_A5A5A6A5_A5A5A6A5);

        // Four-entry store drain
        sAddrQ.push_back(32'h1000); sDataQ.push_back(32'h11111111);
        sAddrQ.push_back(32'h1004); sDataQ.push_back(32'h22222222);
        sAddrQ.push_back(32'h1008); sDataQ.push_back(32'h33333333);
        sAddrQ.push_back(32'h100C); sDataQ.push_back(32'h44444444);
        expectTxn(KindS, 32'h1000, 32'h11111111, 128'h0);
        expectTxn(KindS, 32'h1004, 32'h22222222, 128'h0);
        expectTxn(KindS, 32'h1008, 32'h33333333, 128'h0);
        expectTxn(KindS, 32'h100C, 32'h44444444, 128'h0);
        drain(100);

        // dcache hammering with a pending store
        for (int k = 0; k < 10; k++) dQ.push_back(32'h2000 + 32'(k) * 32'h40);
        sAddrQ.push_back(32'h3000);
        sDataQ.push_back(32'hCAFEF00D);
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 8; k++)
            expectTxn(KindD, 32'h2000 + 32'(k) * 32'h40, 32'h0,
                      memLine(32'h2000 + 32'(k) * 32'h40));
        expectTxn(KindS, 32'h3000, 32'hCAFEF00D, 128'h0);
        for (int k = 8; k < 10; k++)
            expectTxn(KindD, 32'h2000 + 32'(k) * 32'h40, 32'h0,
                      memLine(32'h2000 + 32'(k) * 32'h40));
`else
        for (int k = 0; k < 10; k++)
            expectTxn(KindD, 32'h2000 + 32'(k) * 32'h40, 32'h0,
                      memLine(32'h2000 + 32'(k) * 32'h40));
        expectTxn(KindS, 32'h3000, 32'hCAFEF00D, 128'h0);
`endif
        drain(200);

        // Reset while BUSY, then a stray memAck
        memAuto = 1'b0;
        iQ.push_back(32'h500);
        memQ.push_back('{kind: KindI, addr: 32'h500, wdata: 32'h0, line: 128'h0});
        n = 0;
        while (!bus.memReq && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("memReq before reset", 128'(bus.memReq), 128'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        iQ.delete();
        manualAck = 1'b1;
        chk("memReq after reset", 128'(bus.memReq), 128'd0);
        repeat (5) @(posedge clk);
        #2;
        chk("memReq after stray ack", 128'(bus.memReq), 128'd0);
        chk("acks after stray ack", 128'({bus.iAck, bus.dAck, bus.sAck}), 128'd0);
        memAuto = 1'b1;

        iQ.push_back(32'h600);
        expectTxn(KindI, 32'h600, 32'h0, 128'hA5A5A3A5_A5A5A3A5_A5A5A3A5_A5A5A3A5);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
